// File: rtl/timer_counter_unit_if.sv
// Register bus of the timer/counter unit.
//   master : drives the *_input data and *_write_enable strobes, and samples
//            the read-back registers and the interrupt requests
//   slave  : the timer itself (timer_counter_unit)
// WIDTH must match the WIDTH of the timer_counter_unit attached to it.
interface timer_counter_unit_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] TCNT_input;
  logic             TCNT_write_enable;
  logic [7:0]       TCCR_input;
  logic             TCCR_write_enable;
  logic [WIDTH-1:0] OCR_input;
  logic             OCR_write_enable;
  logic [7:0]       TIMSK_input;
  logic             TIMSK_write_enable;
  logic [7:0]       TIFR_input;
  logic             TIFR_write_enable;

  logic [WIDTH-1:0] TCNT_output;
  logic [7:0]       TCCR_output;
  logic [WIDTH-1:0] OCR_output;
  logic [7:0]       TIMSK_output;
  logic [7:0]       TIFR_output;
  logic             irq_overflow;
  logic             irq_compare;

  modport master (
    output TCNT_input, TCNT_write_enable, TCCR_input, TCCR_write_enable,
           OCR_input, OCR_write_enable, TIMSK_input, TIMSK_write_enable,
           TIFR_input, TIFR_write_enable,
    input  TCNT_output, TCCR_output, OCR_output, TIMSK_output, TIFR_output,
           irq_overflow, irq_compare
  );

  modport slave (
    input  TCNT_input, TCNT_write_enable, TCCR_input, TCCR_write_enable,
           OCR_input, OCR_write_enable, TIMSK_input, TIMSK_write_enable,
           TIFR_input, TIFR_write_enable,
    output TCNT_output, TCCR_output, OCR_output, TIMSK_output, TIFR_output,
           irq_overflow, irq_compare
  );
endinterface

// File: rtl/timer_counter_unit.sv
// Timer/counter with prescaler, overflow and output-compare flags, and CTC mode.
// Ports:
//   sysClock     : system clock, all state on the rising edge
//   system_reset : asynchronous active-low reset
//   bus          : register bus (timer_counter_unit_if.slave)
//                  TCNT  counter        TCCR  [2:0] CS, [3] CTC, [7:4] stored
//                  OCR   compare value  TIMSK [0] TOIE, [1] OCIE
//                  TIFR  [0] TOV, [1] OCF, write-1-to-clear
//                  irq_overflow = TOV & TOIE, irq_compare = OCF & OCIE
module timer_counter_unit #(
  parameter int WIDTH         = 8,
  parameter int PRESCALE_BITS = 10
) (
  input  logic                 sysClock,
  input  logic                 system_reset,
  timer_counter_unit_if.slave  bus
);

  logic [PRESCALE_BITS-1:0] presc_q, presc_d, presc_mask;
  logic [WIDTH-1:0]         tcnt_q, tcnt_d, ocr_q, ocr_d;
  logic [7:0]               tccr_q, tccr_d, timsk_q, timsk_d;
  logic                     tov_q, tov_d, ocf_q, ocf_d;
  logic                     running, tick, match, at_max, tov_set, ocf_set;
  logic [2:0]               cs;
  logic                     ctc;

  assign cs  = tccr_q[2:0];
  assign ctc = tccr_q[3];

  // Terminal prescaler count for the selected divisor (N-1).
  always_comb begin
    running    = 1'b1;
    presc_mask = '0;
    case (cs)
      3'd1:    presc_mask = '0;
      3'd2:    presc_mask = PRESCALE_BITS'(7);
      3'd3:    presc_mask = PRESCALE_BITS'(63);
      3'd4:    presc_mask = PRESCALE_BITS'(255);
      3'd5:    presc_mask = PRESCALE_BITS'(1023);
      default: running    = 1'b0;
    endcase
  end

  // Prescaler is 0 right after a TCCR write, so the tick fires when it
  // reaches N-1: the first tick lands exactly N edges after the write.
  assign tick = running && (presc_q == presc_mask);

  always_comb begin
    presc_d = presc_q + 1'b1;
    if (!running || bus.TCCR_write_enable || tick) presc_d = '0;
  end

  assign match  = (tcnt_q == ocr_q);
  assign at_max = (tcnt_q == '1);

  // A software TCNT load swallows the tick of that cycle, flags included.
  assign tov_set = tick && !bus.TCNT_write_enable && at_max;
  assign ocf_set = tick && !bus.TCNT_write_enable && match;

  always_comb begin
    tcnt_d = tcnt_q;
    if (bus.TCNT_write_enable)  tcnt_d = bus.TCNT_input;
    else if (tick && ctc && match) tcnt_d = '0;
    else if (tick)             tcnt_d = tcnt_q + 1'b1;
  end

  assign ocr_d   = bus.OCR_write_enable   ? bus.OCR_input   : ocr_q;
  assign tccr_d  = bus.TCCR_write_enable  ? bus.TCCR_input  : tccr_q;
  assign timsk_d = bus.TIMSK_write_enable ? bus.TIMSK_input : timsk_q;

  // Hardware set wins over a same-cycle software clear.
  assign tov_d = tov_set | (tov_q & ~(bus.TIFR_write_enable & bus.TIFR_input[0]));
  assign ocf_d = ocf_set | (ocf_q & ~(bus.TIFR_write_enable & bus.TIFR_input[1]));

  always_ff @(posedge sysClock or negedge system_reset) begin
    if (!system_reset) begin
      presc_q <= '0;
      tcnt_q  <= '0;
      ocr_q   <= '0;
      tccr_q  <= '0;
      timsk_q <= '0;
      tov_q   <= 1'b0;
      ocf_q   <= 1'b0;
    end else begin
      presc_q <= presc_d;
      tcnt_q  <= tcnt_d;
      ocr_q   <= ocr_d;
      tccr_q  <= tccr_d;
      timsk_q <= timsk_d;
      tov_q   <= tov_d;
      ocf_q   <= ocf_d;
    end
  end

  assign bus.TCNT_output  = tcnt_q;
  assign bus.TCCR_output  = tccr_q;
  assign bus.OCR_output   = ocr_q;
  assign bus.TIMSK_output = timsk_q;
  assign bus.TIFR_output  = {6'b0, ocf_q, tov_q};
  assign bus.irq_overflow = tov_q & timsk_q[0];
  assign bus.irq_compare  = ocf_q & timsk_q[1];

endmodule

// File: tb/tb_timer_counter_unit.sv
// Directed bench for timer_counter_unit: an 8-bit instance for the counting,
// CTC, flag and priority cases, and a 16-bit instance for /1024 and reset.
module tb_timer_counter_unit;
  logic sysClock = 1'b0;
  logic system_reset;
  int   checks = 0;
  int   errors = 0;

  always #5 sysClock = ~sysClock;

  timer_counter_unit_if #(.WIDTH(8))  b8();
  timer_counter_unit_if #(.WIDTH(16)) b16();

  timer_counter_unit #(.WIDTH(8), .PRESCALE_BITS(10)) u8 (
    .sysClock(sysClock), .system_reset(system_reset), .bus(b8.slave));
  timer_counter_unit #(.WIDTH(16), .PRESCALE_BITS(10)) u16 (
    .sysClock(sysClock), .system_reset(system_reset), .bus(b16.slave));

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge sysClock);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    b8.TCNT_write_enable  = 1'b0; b8.TCCR_write_enable  = 1'b0;
    b8.OCR_write_enable   = 1'b0; b8.TIMSK_write_enable = 1'b0;
    b8.TIFR_write_enable  = 1'b0;
    b16.TCNT_write_enable = 1'b0; b16.TCCR_write_enable = 1'b0;
    b16.OCR_write_enable  = 1'b0; b16.TIMSK_write_enable = 1'b0;
    b16.TIFR_write_enable = 1'b0;
  endtask

  initial begin
    system_reset = 1'b0;
    idle();
    b8.TCNT_input = '0;  b8.TCCR_input = '0;  b8.OCR_input = '0;
    b8.TIMSK_input = '0; b8.TIFR_input = '0;
    b16.TCNT_input = '0; b16.TCCR_input = '0; b16.OCR_input = '0;
    b16.TIMSK_input = '0; b16.TIFR_input = '0;
    step(3);

    // Reset state
    chk("rst_tcnt",  b8.TCNT_output,  0);
    chk("rst_tccr",  b8.TCCR_output,  0);
    chk("rst_ocr",   b8.OCR_output,   0);
    chk("rst_timsk", b8.TIMSK_output, 0);
    chk("rst_tifr",  b8.TIFR_output,  0);
    chk("rst_irqo",  b8.irq_overflow, 0);
    chk("rst_irqc",  b8.irq_compare,  0);
    system_reset = 1'b1;
    step();

    // Normal mode overflow, CS=1, TOIE=1
    b8.TIMSK_input = 8'h01; b8.TIMSK_write_enable = 1'b1;
    b8.TCNT_input  = 8'hFE; b8.TCNT_write_enable  = 1'b1;
    b8.TCCR_input  = 8'h01; b8.TCCR_write_enable  = 1'b1;
    step(); idle();
    chk("ov_load",  b8.TCNT_output,  8'hFE);
    chk("ov_tccr",  b8.TCCR_output,  8'h01);
    chk("ov_timsk", b8.TIMSK_output, 8'h01);
    step();
    chk("ov_ff",    b8.TCNT_output,  8'hFF);
    chk("ov_ff_tifr", b8.TIFR_output, 8'h00);
    chk("ov_ff_irq",  b8.irq_overflow, 0);
    step();
    chk("ov_00",    b8.TCNT_output,  8'h00);
    chk("ov_tifr",  b8.TIFR_output,  8'h01);
    chk("ov_irqo",  b8.irq_overflow, 1);
    chk("ov_irqc",  b8.irq_compare,  0);
    // Stop; the tick of the write cycle still uses the old CS (00==OCR 00 -> OCF)
    b8.TCCR_input = 8'h00; b8.TCCR_write_enable = 1'b1;
    step(); idle();
    chk("stop_tcnt", b8.TCNT_output, 8'h01);
    chk("stop_tifr", b8.TIFR_output, 8'h03);
    chk("stop_irqc", b8.irq_compare, 0);
    b8.TIFR_input = 8'h03; b8.TIFR_write_enable = 1'b1;
    step(); idle();
    chk("w1c_tifr", b8.TIFR_output,  8'h00);
    chk("w1c_irqo", b8.irq_overflow, 0);
    step(3);
    chk("stopped_hold", b8.TCNT_output, 8'h01);

    // CS=2: increments at edges 8, 16, 24 after the write
    b8.TCNT_input = 8'h00; b8.TCNT_write_enable = 1'b1;
    b8.TCCR_input = 8'h02; b8.TCCR_write_enable = 1'b1;
    step(); idle();
    for (int k = 1; k <= 24; k++) begin
      step();
      chk($sformatf("div8_c%0d", k), b8.TCNT_output, k / 8);
    end
    b8.TCCR_input = 8'h00; b8.TCCR_write_enable = 1'b1;
    b8.TIFR_input = 8'h03; b8.TIFR_write_enable = 1'b1;
    step(); idle();
    chk("div8_stop", b8.TCNT_output, 8'h03);

    // CTC, OCR=5, CS=1, OCIE=1
    b8.OCR_input   = 8'h05; b8.OCR_write_enable   = 1'b1;
    b8.TCNT_input  = 8'h00; b8.TCNT_write_enable  = 1'b1;
    b8.TCCR_input  = 8'h09; b8.TCCR_write_enable  = 1'b1;
    b8.TIMSK_input = 8'h02; b8.TIMSK_write_enable = 1'b1;
    step(); idle();
    chk("ctc_start", b8.TCNT_output, 8'h00);
    chk("ctc_ocr",   b8.OCR_output,  8'h05);
    for (int k = 1; k <= 13; k++) begin
      logic exp_ocf;
      step();
      if (k == 8) idle();
      exp_ocf = ((k >= 6) && (k < 8)) || (k >= 12);
      chk($sformatf("ctc_tcnt%0d", k), b8.TCNT_output, k % 6);
      chk($sformatf("ctc_ocf%0d", k),  b8.TIFR_output, {6'b0, exp_ocf, 1'b0});
      chk($sformatf("ctc_irqc%0d", k), b8.irq_compare, exp_ocf);
      if (k == 7) begin
        b8.TIFR_input = 8'h02; b8.TIFR_write_enable = 1'b1;
      end
    end
    b8.TCCR_input  = 8'h00; b8.TCCR_write_enable  = 1'b1;
    b8.TIFR_input  = 8'h03; b8.TIFR_write_enable  = 1'b1;
    b8.TIMSK_input = 8'h00; b8.TIMSK_write_enable = 1'b1;
    step(); idle();

    // Set beats clear on TOV
    b8.TCNT_input = 8'hFE; b8.TCNT_write_enable = 1'b1;
    b8.OCR_input  = 8'h80; b8.OCR_write_enable  = 1'b1;
    b8.TCCR_input = 8'h01; b8.TCCR_write_enable = 1'b1;
    step(); idle();
    step();
    chk("sc_ff", b8.TCNT_output, 8'hFF);
    step();
    chk("sc_00",   b8.TCNT_output, 8'h00);
    chk("sc_tov1", b8.TIFR_output, 8'h01);
    b8.TCNT_input = 8'hFF; b8.TCNT_write_enable = 1'b1;
    step();
    b8.TCNT_write_enable = 1'b0;
    chk("sc_reload", b8.TCNT_output, 8'hFF);
    b8.TIFR_input = 8'h01; b8.TIFR_write_enable = 1'b1;
    step();
    chk("sc_wrap",   b8.TCNT_output, 8'h00);
    chk("sc_setwin", b8.TIFR_output, 8'h01);
    step(); idle();
    chk("sc_clear",  b8.TIFR_output, 8'h00);
    chk("sc_cnt",    b8.TCNT_output, 8'h01);

    // TCNT write beats a compare tick
    b8.OCR_input  = 8'h30; b8.OCR_write_enable  = 1'b1;
    b8.TCNT_input = 8'h30; b8.TCNT_write_enable = 1'b1;
    step(); idle();
    chk("wp_setup", b8.TCNT_output, 8'h30);
    b8.TCNT_input = 8'h10; b8.TCNT_write_enable = 1'b1;
    step(); idle();
    chk("wp_tcnt", b8.TCNT_output, 8'h10);
    chk("wp_tifr", b8.TIFR_output, 8'h00);
    step();
    chk("wp_next", b8.TCNT_output, 8'h11);
    chk("wp_next_tifr", b8.TIFR_output, 8'h00);
    b8.TCNT_input = 8'h2F; b8.TCNT_write_enable = 1'b1;
    step(); idle();
    chk("cmp_2f", b8.TCNT_output, 8'h2F);
    step();
    chk("cmp_30", b8.TCNT_output, 8'h30);
    chk("cmp_30_tifr", b8.TIFR_output, 8'h00);
    step();
    chk("cmp_31", b8.TCNT_output, 8'h31);
    chk("cmp_ocf", b8.TIFR_output, 8'h02);
    // CS=6 is stopped
    b8.TCCR_input = 8'h06; b8.TCCR_write_enable = 1'b1;
    step(); idle();
    step(4);
    chk("cs6_hold", b8.TCNT_output, 8'h32);
    b8.TIFR_input = 8'h03; b8.TIFR_write_enable = 1'b1;
    step(); idle();

    // 16-bit, CS=5, reset mid-count
    b16.TCCR_input = 8'h05; b16.TCCR_write_enable = 1'b1;
    step(); idle();
    step(1023);
    chk("d1k_pre", b16.TCNT_output, 0);
    step();
    chk("d1k_first", b16.TCNT_output, 1);
    step(500);
    #2 system_reset = 1'b0;
    #1;
    chk("ar_tcnt16", b16.TCNT_output, 0);
    chk("ar_tccr16", b16.TCCR_output, 0);
    chk("ar_tifr16", b16.TIFR_output, 0);
    chk("ar_irq16",  {b16.irq_overflow, b16.irq_compare}, 0);
    chk("ar_tcnt8",  b8.TCNT_output,  0);
    chk("ar_tccr8",  b8.TCCR_output,  0);
    chk("ar_ocr8",   b8.OCR_output,   0);
    step(2);
    system_reset = 1'b1;
    step(5);
    chk("ar_idle16", b16.TCNT_output, 0);
    b16.TCCR_input = 8'h05; b16.TCCR_write_enable = 1'b1;
    step(); idle();
    for (int k = 1; k <= 2048; k++) begin
      step();
      if (k == 1023) chk("rr_1023", b16.TCNT_output, 0);
      if (k == 1024) chk("rr_1024", b16.TCNT_output, 1);
      if (k == 2047) chk("rr_2047", b16.TCNT_output, 1);
      if (k == 2048) chk("rr_2048", b16.TCNT_output, 2);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
